// File: rtl/ae_buffer_ctrl.sv
// Acquisition-engine sample buffer controller: packs quantised samples into RAM
// words, runs single-shot or circular fills, and exposes a small host register page.
module ae_buffer_ctrl #(
  parameter int SAMPLE_WIDTH = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 15,
  parameter int DEPTH        = 32768,
  parameter int TH_WIDTH     = 7
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    reg_cs,
  input  logic                    reg_wr,
  input  logic                    reg_rd,
  input  logic [7:0]              reg_addr,
  input  logic [31:0]             reg_d4wt,
  output logic [31:0]             reg_d4rd,
  input  logic                    adc_valid,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  output logic                    ram_ena,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_d4wt,
  output logic                    fill_start,
  output logic                    fill_done,
  output logic                    irq
);

  localparam int LANES  = DATA_WIDTH / SAMPLE_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int BLK    = DEPTH >> TH_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_FILL    = 2'd2,
    ST_FULL    = 2'd3
  } state_t;

  state_t                state;
  logic [TH_WIDTH-1:0]   threshold;
  logic                  mode_circ;
  logic [1:0]            int_en;
  logic [CNT_W-1:0]      count;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [LANE_W-1:0]     lane;
  logic [DATA_WIDTH-1:0] pack;
  logic [DATA_WIDTH-1:0] next_word;
  logic [DATA_WIDTH-1:0] word_q;
  logic                  wr_pend;
  logic                  th_sticky;
  logic                  wrap_sticky;
  logic                  done_sticky;
  logic                  reach_prev;

  logic                  host_wr;
  logic                  wr_ctrl;
  logic                  wr_status;
  logic                  wr_int_en;
  logic                  fill_req;
  logic                  abort_req;
  logic                  last_word;
  logic                  ram_write;
  logic                  final_pending;
  logic                  accept;
  logic                  reach_th;
  logic                  full;
  logic [CNT_W-1:0]      th_words;
  logic                  unused_wdata;

  assign host_wr   = reg_cs & reg_wr;
  assign wr_ctrl   = host_wr & (reg_addr == 8'h00);
  assign wr_status = host_wr & (reg_addr == 8'h04);
  assign wr_int_en = host_wr & (reg_addr == 8'h08);

  // Abort dominates a fill request carried in the same CTRL write.
  assign abort_req = wr_ctrl & reg_d4wt[10];
  assign fill_req  = wr_ctrl & reg_d4wt[8] & ~reg_d4wt[10];

  assign unused_wdata = ^reg_d4wt;

  assign last_word     = (wr_ptr == LAST_ADDR);
  assign ram_write     = wr_pend & ~abort_req;
  assign final_pending = wr_pend & last_word & ~mode_circ;

  assign ram_ena  = ram_write;
  assign ram_we   = ram_write;
  assign ram_addr = wr_ptr;
  assign ram_d4wt = word_q;

  assign fill_done = ram_write & last_word & ~mode_circ & (state == ST_FILL);

  // Samples arriving while the last single-shot word is being written are dropped.
  assign accept = (state == ST_FILL) & sample_valid & ~abort_req & ~fill_req & ~final_pending;

  assign th_words = CNT_W'(threshold) * CNT_W'(BLK);
  assign reach_th = (count >= th_words);
  assign full     = (count == CNT_FULL);
  assign irq      = (done_sticky & int_en[0]) | (th_sticky & int_en[1]);

  always_comb begin
    next_word = pack;
    next_word[int'(lane) * SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample_data;
  end

  always_comb begin
    reg_d4rd = '0;
    if (reg_cs && reg_rd) begin
      case (reg_addr)
        8'h00: begin
          reg_d4rd[TH_WIDTH-1:0] = threshold;
          reg_d4rd[9]            = mode_circ;
        end
        8'h04: reg_d4rd = {9'd0, done_sticky, wrap_sticky, th_sticky, full, reach_th,
                           state, 16'(count)};
        8'h08: reg_d4rd = {30'd0, int_en};
        default: reg_d4rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= ST_IDLE;
      threshold   <= '0;
      mode_circ   <= 1'b0;
      int_en      <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      lane        <= '0;
      pack        <= '0;
      word_q      <= '0;
      wr_pend     <= 1'b0;
      fill_start  <= 1'b0;
      th_sticky   <= 1'b0;
      wrap_sticky <= 1'b0;
      done_sticky <= 1'b0;
      // Threshold 0 reaches immediately; start high so reset alone raises no interrupt.
      reach_prev  <= 1'b1;
    end else begin
      fill_start <= 1'b0;
      wr_pend    <= accept && (lane == LAST_LANE);
      reach_prev <= reach_th;

      if (wr_ctrl) begin
        threshold <= reg_d4wt[TH_WIDTH-1:0];
        mode_circ <= reg_d4wt[9];
      end
      if (wr_int_en) int_en <= reg_d4wt[1:0];

      if (accept) begin
        pack <= next_word;
        if (lane == LAST_LANE) begin
          word_q <= next_word;
          lane   <= '0;
        end else begin
          lane <= lane + 1'b1;
        end
      end

      if (ram_write) begin
        wr_ptr <= last_word ? '0 : wr_ptr + 1'b1;
        if (!full) count <= count + 1'b1;
      end

      // Clear-on-write first so a coincident set event is never lost.
      if (wr_status) begin
        if (reg_d4wt[20]) th_sticky   <= 1'b0;
        if (reg_d4wt[21]) wrap_sticky <= 1'b0;
        if (reg_d4wt[22]) done_sticky <= 1'b0;
      end
      if (reach_th && !reach_prev) th_sticky <= 1'b1;
      if (ram_write && last_word && mode_circ && (state == ST_FILL)) wrap_sticky <= 1'b1;
      if (fill_done) done_sticky <= 1'b1;

      if (abort_req) begin
        state <= ST_IDLE;
        lane  <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_FULL: if (fill_req) state <= ST_PENDING;
          ST_PENDING: begin
            if (adc_valid) begin
              state      <= ST_FILL;
              fill_start <= 1'b1;
              count      <= '0;
              wr_ptr     <= '0;
              lane       <= '0;
            end
          end
          ST_FILL: begin
            if (fill_req)       state <= ST_PENDING;
            else if (fill_done) state <= ST_FULL;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ae_buffer_ctrl.sv
// Directed self-checking bench for ae_buffer_ctrl with DEPTH=16, TH_WIDTH=2 (BLK=4),
// 4-bit samples packed into 32-bit words.
module tb_ae_buffer_ctrl;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        reg_cs = 1'b0;
  logic        reg_wr = 1'b0;
  logic        reg_rd = 1'b0;
  logic [7:0]  reg_addr = '0;
  logic [31:0] reg_d4wt = '0;
  logic [31:0] reg_d4rd;
  logic        adc_valid = 1'b0;
  logic        sample_valid = 1'b0;
  logic [3:0]  sample_data = '0;
  logic        ram_ena;
  logic        ram_we;
  logic [3:0]  ram_addr;
  logic [31:0] ram_d4wt;
  logic        fill_start;
  logic        fill_done;
  logic        irq;

  int total = 0;
  int passed = 0;
  int start_pulses = 0;
  int done_pulses = 0;
  logic [3:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] st;

  ae_buffer_ctrl #(
    .SAMPLE_WIDTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .TH_WIDTH(2)
  ) dut (
    .clk(clk), .rst_b(rst_b), .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_addr(reg_addr), .reg_d4wt(reg_d4wt), .reg_d4rd(reg_d4rd),
    .adc_valid(adc_valid), .sample_valid(sample_valid), .sample_data(sample_data),
    .ram_ena(ram_ena), .ram_we(ram_we), .ram_addr(ram_addr), .ram_d4wt(ram_d4wt),
    .fill_start(fill_start), .fill_done(fill_done), .irq(irq)
  );

  always #5 clk = ~clk;

  // Log RAM writes and pulses mid-cycle.
  always @(negedge clk) begin
    if (rst_b) begin
      if (ram_ena) begin
        wa_q.push_back(ram_addr);
        wd_q.push_back(ram_d4wt);
      end
      if (fill_start) start_pulses++;
      if (fill_done) done_pulses++;
    end
  end

  task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
    reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_d4wt = d;
    @(posedge clk); #1;
    reg_cs = 1'b0; reg_wr = 1'b0; reg_d4wt = '0;
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk); #1;
    reg_cs = 1'b1; reg_rd = 1'b1; reg_addr = a;
    #1 d = reg_d4rd;
    reg_cs = 1'b0; reg_rd = 1'b0;
  endtask

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); start_pulses = 0; done_pulses = 0;
  endtask

  task automatic adc_pulse();
    adc_valid = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0;
  endtask

  task automatic send_samples(input int n);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample_data = 4'(i % 16);
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    idle_cycles(3);
    total++; if ({ram_ena, ram_we, ram_addr, ram_d4wt, fill_start, fill_done, irq} !== '0)
      $display("[TB] FAIL reset_outputs: got %h required 0", {ram_ena, ram_we, ram_addr, ram_d4wt, fill_start, fill_done, irq}); else passed++;
    rst_b = 1'b1;
    idle_cycles(2);
    reg_read(8'h00, d);
    total++; if (d !== 32'h0) $display("[TB] FAIL reset_ctrl: got %h required 0", d); else passed++;
    reg_read(8'h04, d);
    total++; if (d !== 32'h0004_0000) $display("[TB] FAIL reset_status: got %h required 00040000", d); else passed++;
    reg_read(8'h08, d);
    total++; if (d !== 32'h0) $display("[TB] FAIL reset_int_en: got %h required 0", d); else passed++;
    reg_read(8'h0C, d);
    total++; if (d !== 32'h0) $display("[TB] FAIL unmapped_read: got %h required 0", d); else passed++;
  endtask

  task automatic test_single_shot();
    logic [31:0] exp;
    clear_log();
    reg_write(8'h00, 32'h100);
    adc_pulse();
    total++; if (fill_start !== 1'b1) $display("[TB] FAIL ss_fill_start: got %b required 1", fill_start); else passed++;
    send_samples(128);
    idle_cycles(3);
    total++; if (wa_q.size() !== 16) $display("[TB] FAIL ss_write_count: got %0d required 16", wa_q.size()); else passed++;
    for (int i = 0; i < 16; i++) begin
      exp = (i % 2 == 0) ? 32'h7654_3210 : 32'hFEDC_BA98;
      total++;
      if (i >= wa_q.size()) $display("[TB] FAIL ss_word%0d: missing write", i);
      else if (wa_q[i] !== 4'(i) || wd_q[i] !== exp)
        $display("[TB] FAIL ss_word%0d: got addr %0d data %h required addr %0d data %h", i, wa_q[i], wd_q[i], i, exp);
      else passed++;
    end
    total++; if (start_pulses !== 1) $display("[TB] FAIL ss_start_pulses: got %0d required 1", start_pulses); else passed++;
    total++; if (done_pulses !== 1) $display("[TB] FAIL ss_done_pulses: got %0d required 1", done_pulses); else passed++;
    reg_read(8'h04, st);
    total++; if (st[17:16] !== 2'd3) $display("[TB] FAIL ss_state: got %0d required 3", st[17:16]); else passed++;
    total++; if (st[15:0] !== 16'd16) $display("[TB] FAIL ss_count: got %0d required 16", st[15:0]); else passed++;
    total++; if (st[19] !== 1'b1) $display("[TB] FAIL ss_full: got %b required 1", st[19]); else passed++;
    total++; if (st[22] !== 1'b1) $display("[TB] FAIL ss_done_sticky: got %b required 1", st[22]); else passed++;
    total++; if (irq !== 1'b0) $display("[TB] FAIL ss_irq_masked: got %b required 0", irq); else passed++;
  endtask

  task automatic test_threshold();
    reg_write(8'h04, 32'h0070_0000);
    reg_write(8'h08, 32'h2);
    reg_write(8'h00, 32'h102);
    adc_pulse();
    send_samples(56);
    idle_cycles(2);
    reg_read(8'h04, st);
    total++; if (st[15:0] !== 16'd7) $display("[TB] FAIL th_count7: got %0d required 7", st[15:0]); else passed++;
    total++; if (st[18] !== 1'b0 || st[20] !== 1'b0)
      $display("[TB] FAIL th_below: got reach %b sticky %b required 0 0", st[18], st[20]); else passed++;
    total++; if (irq !== 1'b0) $display("[TB] FAIL th_irq_low: got %b required 0", irq); else passed++;
    send_samples(8);
    idle_cycles(2);
    reg_read(8'h04, st);
    total++; if (st[15:0] !== 16'd8) $display("[TB] FAIL th_count8: got %0d required 8", st[15:0]); else passed++;
    total++; if (st[18] !== 1'b1 || st[20] !== 1'b1)
      $display("[TB] FAIL th_reached: got reach %b sticky %b required 1 1", st[18], st[20]); else passed++;
    total++; if (irq !== 1'b1) $display("[TB] FAIL th_irq_high: got %b required 1", irq); else passed++;
    reg_write(8'h04, 32'h0010_0000);
    total++; if (irq !== 1'b0) $display("[TB] FAIL th_irq_cleared: got %b required 0", irq); else passed++;
    reg_read(8'h04, st);
    total++; if (st[20] !== 1'b0 || st[18] !== 1'b1)
      $display("[TB] FAIL th_sticky_clear: got reach %b sticky %b required 1 0", st[18], st[20]); else passed++;
  endtask

  task automatic test_circular();
    logic [31:0] exp;
    reg_write(8'h08, 32'h0);
    reg_write(8'h04, 32'h0070_0000);
    reg_write(8'h00, 32'h300);
    clear_log();
    adc_pulse();
    send_samples(160);
    idle_cycles(3);
    total++; if (wa_q.size() !== 20) $display("[TB] FAIL circ_write_count: got %0d required 20", wa_q.size()); else passed++;
    for (int i = 0; i < 20; i++) begin
      exp = (i % 2 == 0) ? 32'h7654_3210 : 32'hFEDC_BA98;
      total++;
      if (i >= wa_q.size()) $display("[TB] FAIL circ_word%0d: missing write", i);
      else if (wa_q[i] !== 4'(i % 16) || wd_q[i] !== exp)
        $display("[TB] FAIL circ_word%0d: got addr %0d data %h required addr %0d data %h", i, wa_q[i], wd_q[i], i % 16, exp);
      else passed++;
    end
    reg_read(8'h04, st);
    total++; if (st[21] !== 1'b1) $display("[TB] FAIL circ_wrap_sticky: got %b required 1", st[21]); else passed++;
    total++; if (st[15:0] !== 16'd16) $display("[TB] FAIL circ_count_sat: got %0d required 16", st[15:0]); else passed++;
    total++; if (st[17:16] !== 2'd2) $display("[TB] FAIL circ_state: got %0d required 2", st[17:16]); else passed++;
    total++; if (done_pulses !== 0 || st[22] !== 1'b0)
      $display("[TB] FAIL circ_no_done: got pulses %0d sticky %b required 0 0", done_pulses, st[22]); else passed++;
  endtask

  task automatic test_abort_mid_word();
    reg_write(8'h00, 32'h400);
    reg_write(8'h00, 32'h100);
    clear_log();
    adc_pulse();
    send_samples(43);
    reg_write(8'h00, 32'h400);
    idle_cycles(3);
    total++; if (wa_q.size() !== 5) $display("[TB] FAIL abort_write_count: got %0d required 5", wa_q.size()); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (i >= wa_q.size()) $display("[TB] FAIL abort_addr%0d: missing write", i);
      else if (wa_q[i] !== 4'(i)) $display("[TB] FAIL abort_addr%0d: got %0d required %0d", i, wa_q[i], i);
      else passed++;
    end
    reg_read(8'h04, st);
    total++; if (st[17:16] !== 2'd0) $display("[TB] FAIL abort_state: got %0d required 0", st[17:16]); else passed++;
    total++; if (st[15:0] !== 16'd5) $display("[TB] FAIL abort_count: got %0d required 5", st[15:0]); else passed++;
    send_samples(8);
    idle_cycles(2);
    total++; if (wa_q.size() !== 5) $display("[TB] FAIL abort_idle_ignored: got %0d writes required 5", wa_q.size()); else passed++;
    clear_log();
    reg_write(8'h00, 32'h100);
    adc_pulse();
    send_samples(8);
    idle_cycles(2);
    total++;
    if (wa_q.size() !== 1) $display("[TB] FAIL restart_write: got %0d writes required 1", wa_q.size());
    else if (wa_q[0] !== 4'd0 || wd_q[0] !== 32'h7654_3210)
      $display("[TB] FAIL restart_write: got addr %0d data %h required addr 0 data 76543210", wa_q[0], wd_q[0]);
    else passed++;
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    reg_write(8'h00, 32'h400);
    clear_log();
    reg_write(8'h00, 32'h500);
    adc_pulse();
    idle_cycles(3);
    reg_read(8'h04, st);
    total++; if (st[17:16] !== 2'd0) $display("[TB] FAIL simul_state: got %0d required 0", st[17:16]); else passed++;
    total++; if (start_pulses !== 0) $display("[TB] FAIL simul_no_start: got %0d required 0", start_pulses); else passed++;
    reg_read(8'h00, d);
    total++; if (d !== 32'h0) $display("[TB] FAIL simul_ctrl_read: got %h required 0", d); else passed++;
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] d;
    reg_write(8'h00, 32'h100);
    adc_pulse();
    send_samples(16);
    total++; if (ram_ena !== 1'b1 || ram_addr !== 4'd1 || ram_d4wt !== 32'hFEDC_BA98)
      $display("[TB] FAIL pre_reset_write: got ena %b addr %0d data %h required 1 1 fedcba98", ram_ena, ram_addr, ram_d4wt); else passed++;
    rst_b = 1'b0;
    #1;
    total++; if ({ram_ena, ram_we, ram_addr, ram_d4wt, fill_start, fill_done, irq} !== '0)
      $display("[TB] FAIL midfill_reset_outputs: got %h required 0", {ram_ena, ram_we, ram_addr, ram_d4wt, fill_start, fill_done, irq}); else passed++;
    idle_cycles(2);
    rst_b = 1'b1;
    idle_cycles(2);
    reg_read(8'h04, d);
    total++; if (d !== 32'h0004_0000) $display("[TB] FAIL midfill_status: got %h required 00040000", d); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_threshold();
    test_circular();
    test_abort_mid_word();
    test_simultaneous();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ae_buffer_ctrl.md
# ae_buffer_ctrl

Parametrised acquisition-engine sample buffer controller: it packs quantised samples from the rate adaptor into RAM words and writes them to the AE sample RAM. It supports single-shot and circular fill modes, a programmable threshold, sticky status and a maskable interrupt. It sits between the rate adaptor and the AE sample RAM, owns its own host register page, and replaces the fixed-size fill logic in the AE top level.

## Interface
- SAMPLE_WIDTH, 4, bits per quantised sample; must divide DATA_WIDTH; DATA_WIDTH/SAMPLE_WIDTH must be a power of 2
- DATA_WIDTH, 32, RAM word width
- ADDR_WIDTH, 15, RAM word address width
- DEPTH, 32768, buffer size in words; power of 2, at most 2^ADDR_WIDTH
- TH_WIDTH, 7, threshold field width; threshold granule BLK = DEPTH >> TH_WIDTH words
- clk  in  1  system clock
- rst_b  in  1  asynchronous, active-low reset
- reg_cs  in  1  register page select
- reg_wr  in  1  host write strobe
- reg_rd  in  1  host read strobe
- reg_addr  in  8  byte address
- reg_d4wt  in  32  host write data
- reg_d4rd  out  32  host read data; combinational, valid in the same cycle as reg_rd
- adc_valid  in  1  raw ADC sample strobe, used for fill start alignment
- sample_valid  in  1  quantised sample strobe from the rate adaptor
- sample_data  in  SAMPLE_WIDTH  quantised sample
- ram_ena, ram_we  out  1  RAM enable and write enable
- ram_addr  out  ADDR_WIDTH  RAM word address
- ram_d4wt  out  DATA_WIDTH  RAM write data
- fill_start  out  1  one-cycle pulse marking the start of a fill
- fill_done  out  1  one-cycle pulse when a single-shot fill completes
- irq  out  1  level interrupt

## Operation
Registers (addresses not listed read 0; writes to them are ignored):
- 0x00 CTRL
  - [TH_WIDTH-1:0] threshold, R/W
  - bit8 fill request, write-1 pulse, reads 0
  - bit9 mode, R/W: 0 = single-shot, 1 = circular
  - bit10 abort, write-1 pulse, reads 0
- 0x04 STATUS
  - [15:0] word count, zero-extended
  - bits 17:16 state: 0 IDLE, 1 PENDING, 2 FILL, 3 FULL
  - bit18 reach_th
  - bit19 full
  - bit20 th_sticky
  - bit21 wrap_sticky
  - bit22 done_sticky
  - writing 1 to any of bits 22:20 clears that bit
- 0x08 INT_EN
  - bit0 enables done_sticky onto irq
  - bit1 enables th_sticky onto irq
  - irq = (done_sticky & en0) | (th_sticky & en1)

State machine:
- IDLE→PENDING, FILL→PENDING, FULL→PENDING: on a fill request. A request during FILL restarts the fill.
- PENDING→FILL: on the first adc_valid. fill_start pulses high for the one cycle after that edge. Entering FILL clears count, write pointer and pack lane to 0.
- FILL, single-shot: after word DEPTH-1 is written, go to FULL; fill_done pulses once; done_sticky is set.
- FILL, circular: after word DEPTH-1 is written, the write pointer wraps to 0, wrap_sticky is set, and the state stays FILL.
- Any state→IDLE: on abort. The partial word is discarded and the lane cleared; count is retained. If abort and fill request are written in the same cycle, abort wins.

Packing and counting:
- sample_valid is accepted only in FILL and is ignored otherwise.
- Sample k of a word lands in bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH], LSB first.
- count = words written since fill start, saturating at DEPTH.
- full = (count == DEPTH).
- reach_th = (count >= threshold*BLK). Threshold 0 therefore gives reach_th = 1.
- th_sticky is set on the rising edge of reach_th.

## Timing
- Reset values:
  - all registers, sticky bits and count are 0; state is IDLE
  - ram_ena, ram_we, ram_addr, ram_d4wt, fill_start, fill_done and irq are all 0
- A register write takes effect at the clock edge of the strobe; a read reflects the pre-edge value.
- RAM write:
  - ram_ena = ram_we = 1 for exactly one cycle, the cycle after the last sample of a word is accepted
  - that cycle carries the complete packed word and the current pointer
  - the pointer increments at the end of that cycle
  - ram_ena = 0 at all other times
- Back-to-back sample_valid on every cycle is sustained with no loss.
- fill_done pulses in the same cycle as the final RAM write.
- Circular wrap: the write to word DEPTH-1 is immediately followed by writes to word 0.
- sample_valid in the cycle fill_start is high is accepted as sample 0.
- An abort in the same cycle as a pending RAM write suppresses that write.

## Test plan
Bench parameters: DEPTH=16, TH_WIDTH=2 (BLK=4), SAMPLE_WIDTH=4, DATA_WIDTH=32.
- Single-shot fill:
  - stimulus: fill request, one adc_valid, then 128 samples with values 0..F repeating
  - required: fill_start one-cycle pulse; 16 writes to addresses 0..15, each with data 0x76543210 or 0xFEDCBA98; fill_done once; state FULL; count 16; full = 1
- Threshold:
  - stimulus: threshold 2 in single-shot mode
  - required: reach_th and th_sticky rise after the 8th write; with INT_EN = 2, irq goes high; writing 1 to STATUS bit20 drops irq
- Circular mode:
  - stimulus: 160 samples
  - required: writes 0..15, then 0..3; wrap_sticky = 1; count saturates at 16; no fill_done
- Abort mid-word:
  - stimulus: abort after 3 samples into word 5
  - required: no write to address 5; state IDLE; count 5; a following request plus adc_valid restarts writes at address 0
- Simultaneous CTRL write:
  - stimulus: a single CTRL write with bits 8 and 10 set
  - required: state IDLE; no fill_start
- Reset mid-fill:
  - stimulus: rst_b low while in FILL
  - required: all outputs 0; state IDLE
